// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl
//
// Sequencing controller for the vending machine change subtractor. A vend
// request latches the paid amount and the item price. The controller then
// forms paid - price with a two's-complement subtract (a + ~b + 1, where the
// borrow is the inverted carry-out). It hands the result to the coin ejector
// one coin at a time over a valid/ack handshake. When paid < price the whole
// paid amount is refunded instead and the shortfall is flagged.
//
// Ports:
//   clk         rising-edge system clock
//   rst         asynchronous, active-high reset
//   start       vend request pulse, only sampled while idle
//   paid        amount inserted (0..31), sampled with start
//   price       item price (0..31), sampled with start
//   coin_ack    ejector accepted the offered coin
//   busy        high whenever a transaction is in progress
//   coin_valid  a coin is being offered to the ejector
//   coin_type   offered coin: 2'b10 = 10, 2'b01 = 5, 2'b00 = 1
//   change_amt  latched amount to dispense for this transaction
//   remaining   amount still to be dispensed
//   coin_count  coins handed over in the current transaction
//   short       paid < price, the transaction is a refund
//   done        one-cycle pulse marking the end of a transaction
// ---------------------------------------------------------------------------
module change_dispense_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] paid,
    input  logic [4:0] price,
    input  logic       coin_ack,
    output logic       busy,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic [4:0] change_amt,
    output logic [4:0] remaining,
    output logic [2:0] coin_count,
    output logic       short,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        SELECT = 3'd2,
        OFFER  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state;
    logic [4:0] paid_q;
    logic [4:0] price_q;
    logic [5:0] diff;

    // Face value of a coin code. Code 2'b11 is never latched, so it is
    // folded into the 1-unit case.
    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            2'b10:   coin_value = 5'd10;
            2'b01:   coin_value = 5'd5;
            default: coin_value = 5'd1;
        endcase
    endfunction

    // Subtract datapath: paid + ~price + 1. Bit 5 is the carry-out, so a
    // clear bit 5 means a borrow, which means paid < price.
    always_comb begin
        diff = {1'b0, paid_q} + {1'b0, ~price_q} + 6'd1;
    end

    // Single-process FSM. Every output is a register that is updated on the
    // transition into the state where it matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            paid_q     <= 5'd0;
            price_q    <= 5'd0;
            busy       <= 1'b0;
            coin_valid <= 1'b0;
            coin_type  <= 2'b00;
            change_amt <= 5'd0;
            remaining  <= 5'd0;
            coin_count <= 3'd0;
            short      <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        paid_q     <= paid;
                        price_q    <= price;
                        coin_count <= 3'd0;
                        short      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (diff[5]) begin
                        change_amt <= diff[4:0];
                        remaining  <= diff[4:0];
                        short      <= 1'b0;
                    end else begin
                        change_amt <= paid_q;
                        remaining  <= paid_q;
                        short      <= 1'b1;
                    end
                    state <= SELECT;
                end
                SELECT: begin
                    if (remaining == 5'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (remaining >= 5'd10) begin
                            coin_type <= 2'b10;
                        end else if (remaining >= 5'd5) begin
                            coin_type <= 2'b01;
                        end else begin
                            coin_type <= 2'b00;
                        end
                        coin_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    // coin_valid and coin_type stay put until the ejector acks.
                    if (coin_ack) begin
                        coin_valid <= 1'b0;
                        remaining  <= remaining - coin_value(coin_type);
                        coin_count <= coin_count + 3'd1;
                        state      <= SELECT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
